// File: rtl/serial_sub_pkg.sv
// rtl/serial_sub_pkg.sv - shared types and sizing helper for the bit-serial subtractor
package serial_sub_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} sub_state_t;

    // Bit counter must be able to hold WIDTH itself
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - request/result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             ovf;

    modport master (
        output start, a, b, b_in,
        input  busy, done, diff, b_out, ovf
    );

    modport slave (
        input  start, a, b, b_in,
        output busy, done, diff, b_out, ovf
    );
endinterface

// File: rtl/serial_subtractor_full_sub.sv
// rtl/serial_subtractor_full_sub.sv - single-bit combinational full subtractor cell
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = x ^ y ^ bi;
    assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first serial a - b - b_in through one full_sub cell
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    localparam int CW = cnt_width(WIDTH);

    sub_state_t       state, state_next;
    logic [WIDTH-1:0] a_sh, b_sh, r_sh, r_next;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt;
    logic             brw, a_msb, b_msb;
    logic             b_out_q, ovf_q;
    logic             d_bit, bo_bit;
    logic             accept, last_bit;

    full_sub u_full_sub (
        .x  (a_sh[0]),
        .y  (b_sh[0]),
        .bi (brw),
        .d  (d_bit),
        .bo (bo_bit)
    );

    // Result fills from the MSB end so the final bit lands everything in place
    generate
        if (WIDTH == 1) begin : g_r_one
            assign r_next = d_bit;
        end else begin : g_r_wide
            assign r_next = {d_bit, r_sh[WIDTH-1:1]};
        end
    endgenerate

    assign accept   = bus.start && (state != RUN);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (last_bit)  state_next = DONE;
            DONE:    state_next = bus.start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            a_sh    <= '0;
            b_sh    <= '0;
            r_sh    <= '0;
            brw     <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            cnt     <= '0;
            diff_q  <= '0;
            b_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sh  <= bus.a;
                b_sh  <= bus.b;
                brw   <= bus.b_in;
                a_msb <= bus.a[WIDTH-1];
                b_msb <= bus.b[WIDTH-1];
                cnt   <= '0;
            end else if (state == RUN) begin
                a_sh <= a_sh >> 1;
                b_sh <= b_sh >> 1;
                r_sh <= r_next;
                brw  <= bo_bit;
                cnt  <= cnt + CW'(1);
                if (last_bit) begin
                    diff_q  <= r_next;
                    b_out_q <= bo_bit;
                    ovf_q   <= (a_msb ^ b_msb) & (r_next[WIDTH-1] ^ a_msb);
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.done  = (state == DONE);
    assign bus.diff  = diff_q;
    assign bus.b_out = b_out_q;
    assign bus.ovf   = ovf_q;

endmodule
